// File: rtl/uart_ascii_hex_parser.sv
// Assembles pairs of ASCII hex characters from the UART receiver into bytes
// for the 7-segment decoders, flagging malformed characters and stale high nibbles.
module uart_ascii_hex_parser #(
  parameter int CLKS_TIMEOUT = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Byte,
  output logic       o_Byte_DV,
  output logic       o_Error,
  output logic [7:0] o_Error_Count,
  output logic       o_Busy
);

  localparam int CNT_W = $clog2(CLKS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HAVE_HI = 1'b1
  } state_t;

  // Returns {is_hex, nibble}; letters fold onto 10..15 via their low nibble.
  function automatic logic [4:0] decode_hex(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0_0000;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      r = {1'b1, c[3:0]};
    end else if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'b0_0000;
    end
    return r;
  endfunction

  function automatic logic is_separator(input logic [7:0] c);
    logic r;
    case (c)
      8'h20, 8'h0D, 8'h0A: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       hi_r, hi_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       byte_s;
  logic             byte_dv_s;
  logic             err_s;
  logic [4:0]       dec_s;
  logic             sep_s;

  assign dec_s = decode_hex(i_RX_Byte);
  assign sep_s = is_separator(i_RX_Byte);

  // Next-state and next-output decode; a DV always takes priority over the timeout.
  always_comb begin
    state_s   = state_r;
    hi_s      = hi_r;
    cnt_s     = cnt_r;
    byte_s    = o_Byte;
    byte_dv_s = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_RX_DV) begin
          if (dec_s[4]) begin
            hi_s    = dec_s[3:0];
            cnt_s   = '0;
            state_s = HAVE_HI;
          end else if (sep_s) begin
            state_s = IDLE;
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HAVE_HI: begin
        if (i_RX_DV) begin
          if (dec_s[4]) begin
            byte_s    = {hi_r, dec_s[3:0]};
            byte_dv_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          hi_s    = 4'h0;
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          err_s   = 1'b1;
          hi_s    = 4'h0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        hi_s    = 4'h0;
        state_s = IDLE;
      end
    endcase
  end

  // State, nibble holding register and timeout counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r <= IDLE;
      hi_r    <= 4'h0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      hi_r    <= hi_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered outputs; the error counter holds once it reaches 255.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Byte        <= 8'h00;
      o_Byte_DV     <= 1'b0;
      o_Error       <= 1'b0;
      o_Error_Count <= 8'h00;
      o_Busy        <= 1'b0;
    end else begin
      o_Byte    <= byte_s;
      o_Byte_DV <= byte_dv_s;
      o_Error   <= err_s;
      o_Busy    <= (state_s == HAVE_HI);
      if (err_s && (o_Error_Count != 8'hFF)) begin
        o_Error_Count <= o_Error_Count + 8'd1;
      end else begin
        o_Error_Count <= o_Error_Count;
      end
    end
  end

endmodule

// File: tb/tb_uart_ascii_hex_parser.sv
// Randomised bench for uart_ascii_hex_parser: a character-level reference model
// is compared against every output on each falling edge, plus directed literal checks.
module tb_uart_ascii_hex_parser;

  localparam int T = 16;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic [7:0] o_Byte;
  logic       o_Byte_DV;
  logic       o_Error;
  logic [7:0] o_Error_Count;
  logic       o_Busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  uart_ascii_hex_parser #(.CLKS_TIMEOUT(T)) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_RX_DV(i_RX_DV),
    .i_RX_Byte(i_RX_Byte),
    .o_Byte(o_Byte),
    .o_Byte_DV(o_Byte_DV),
    .o_Error(o_Error),
    .o_Error_Count(o_Error_Count),
    .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Character value: 0..15 for hex, -1 for separator, -2 for anything else.
  function automatic int char_val(input logic [7:0] c);
    logic [7:0] lc;
    lc = c | 8'h20;
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= 8'h41 && lc >= "a" && lc <= "f" && (c <= 8'h46 || c >= 8'h61)) return int'(lc) - 87;
    if (c == 8'h20 || c == 8'h0D || c == 8'h0A) return -1;
    return -2;
  endfunction

  // Reference model: a pending high digit, its age in idle cycles, and output values.
  bit       m_pending;
  int       m_hi, m_age;
  logic [7:0] m_byte;
  bit       m_dv, m_err;
  int       m_cnt;

  always @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      m_pending <= 1'b0; m_hi <= 0; m_age <= 0;
      m_byte <= 8'h00; m_dv <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
    end else begin
      m_dv  <= 1'b0;
      m_err <= 1'b0;
      if (i_RX_DV) begin
        if (m_pending) begin
          m_pending <= 1'b0;
          if (char_val(i_RX_Byte) >= 0) begin
            m_byte <= 8'(m_hi * 16 + char_val(i_RX_Byte));
            m_dv   <= 1'b1;
          end else begin
            m_err <= 1'b1;
            m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
          end
        end else if (char_val(i_RX_Byte) >= 0) begin
          m_pending <= 1'b1;
          m_hi      <= char_val(i_RX_Byte);
          m_age     <= 0;
        end else if (char_val(i_RX_Byte) == -2) begin
          m_err <= 1'b1;
          m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end else if (m_pending) begin
        if (m_age + 1 == T) begin
          m_pending <= 1'b0;
          m_err     <= 1'b1;
          m_cnt     <= (m_cnt < 255) ? m_cnt + 1 : 255;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  always @(negedge i_Clk) begin
    if (chk_en) begin
      check("byte",      32'(o_Byte),        32'(m_byte));
      check("byte_dv",   32'(o_Byte_DV),     32'(m_dv));
      check("error",     32'(o_Error),       32'(m_err));
      check("err_count", 32'(o_Error_Count), 32'(m_cnt));
      check("busy",      32'(o_Busy),        32'(m_pending));
    end
  end

  // Called at a falling edge; the character is sampled on the next rising edge.
  task automatic send(input logic [7:0] c);
    i_RX_DV   = 1'b1;
    i_RX_Byte = c;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  string hexchars = "0123456789abcdefABCDEF";
  logic [7:0] seps [3] = '{8'h20, 8'h0D, 8'h0A};

  initial begin
    #1 i_Rst = 1'b1;
    @(negedge i_Clk);
    chk_en = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    check("rst_byte", 32'(o_Byte), 32'h00);
    check("rst_busy", 32'(o_Busy), 32'h0);
    check("rst_cnt",  32'(o_Error_Count), 32'h00);
    idle(2);

    send("4");
    check("busy_mid_pair", 32'(o_Busy), 32'h1);
    idle(3);
    send("1");
    check("pair_41", 32'(o_Byte), 32'h41);
    check("pair_41_dv", 32'(o_Byte_DV), 32'h1);
    idle(1);
    check("busy_after", 32'(o_Busy), 32'h0);

    send("a"); idle(2); send("F");
    check("pair_af", 32'(o_Byte), 32'hAF);
    send(8'h20); send(8'h0D); send(8'h0A);
    send("0"); send("9");
    check("pair_09", 32'(o_Byte), 32'h09);
    check("no_err_yet", 32'(o_Error_Count), 32'h00);

    idle(2);
    send("G");
    check("invalid_idle_err", 32'(o_Error), 32'h1);
    send("3"); send("Z");
    check("invalid_hi_err", 32'(o_Error), 32'h1);
    check("err_count_2", 32'(o_Error_Count), 32'h02);
    check("byte_kept", 32'(o_Byte), 32'h09);

    idle(2);
    send("7");
    idle(T - 1);
    check("timeout_not_yet", 32'(o_Error), 32'h0);
    check("timeout_busy", 32'(o_Busy), 32'h1);
    idle(1);
    check("timeout_err", 32'(o_Error), 32'h1);
    check("timeout_busy_drop", 32'(o_Busy), 32'h0);
    idle(4);
    send("8"); send("5");
    check("pair_85", 32'(o_Byte), 32'h85);
    check("err_count_3", 32'(o_Error_Count), 32'h03);

    idle(2);
    send("7");
    idle(T - 1);
    send("E");
    check("dv_beats_timeout", 32'(o_Byte), 32'h7E);
    check("dv_beats_timeout_err", 32'(o_Error), 32'h0);
    idle(1);
    check("dv_beats_timeout_cnt", 32'(o_Error_Count), 32'h03);

    send("3");
    #2 i_Rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(o_Busy), 32'h0);
    check("async_rst_cnt", 32'(o_Error_Count), 32'h00);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    send("4"); send("2");
    check("pair_after_rst", 32'(o_Byte), 32'h42);

    for (int i = 0; i < 300; i++) send("x");
    check("err_saturate", 32'(o_Error_Count), 32'hFF);

    @(negedge i_Clk);
    #2 i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5)      send(hexchars[$urandom_range(0, 21)]);
      else if (r == 6) send(seps[$urandom_range(0, 2)]);
      else             send(8'($urandom_range(0, 255)));
      idle(int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2)));
    end
    idle(T + 2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
